// File: rtl/vend_pkg.sv
// Shared types and coin constants for the change-return datapath.
package vend_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        EJECT,
        WAIT_DROP,
        DONE
    } state_t;

    typedef enum logic {
        COIN5,
        COIN10
    } coin_t;

    // Coin values expressed in 5-rupee units.
    localparam int COIN5_UNITS  = 1;
    localparam int COIN10_UNITS = 2;

endpackage

// File: rtl/coin_stock.sv
// One coin hopper's stock counter: saturating refill add combined with a
// same-cycle decrement when a coin is confirmed dropped.
module coin_stock #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             refill_valid,
    input  logic [CNT_W-1:0] refill_amt,
    input  logic             dec,
    output logic [CNT_W-1:0] stock
);

    localparam logic [CNT_W:0] MAX_CNT = {1'b0, {CNT_W{1'b1}}};

    logic [CNT_W-1:0] stock_q;
    logic [CNT_W-1:0] stock_d;
    logic [CNT_W:0]   sum;

    // The extra top bit holds the overflow so the clamp sees the true total.
    always_comb begin
        sum = {1'b0, stock_q} + (refill_valid ? {1'b0, refill_amt} : '0);
        if (dec && (sum != '0)) begin
            sum = sum - (CNT_W+1)'(1);
        end
        stock_d = (sum > MAX_CNT) ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stock_q <= '0;
        end else begin
            stock_q <= stock_d;
        end
    end

    assign stock = stock_q;

endmodule

// File: rtl/change_dispenser.sv
// Change-return controller: pays an amount out of 10- and 5-rupee hoppers,
// largest coin first, waiting for each drop confirmation before the next coin.
module change_dispenser
    import vend_pkg::*;
#(
    parameter int AMT_W       = 5,
    parameter int CNT_W       = 8,
    parameter int PULSE_CYC   = 4,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    input  logic [AMT_W-1:0] req_amt,
    output logic             req_ready,
    output logic             done,
    output logic             err,
    output logic [AMT_W-1:0] remain,
    output logic             jam,
    output logic             eject10,
    output logic             eject5,
    input  logic             drop10,
    input  logic             drop5,
    input  logic             refill_valid,
    input  logic [CNT_W-1:0] refill10,
    input  logic [CNT_W-1:0] refill5,
    output logic [CNT_W-1:0] stock10,
    output logic [CNT_W-1:0] stock5
);

    // One timer serves both the eject pulse and the drop-wait window.
    localparam int TMR_W = $clog2(TIMEOUT_CYC + PULSE_CYC + 1);
    localparam logic [TMR_W-1:0] PULSE_LAST   = TMR_W'(PULSE_CYC - 1);
    localparam logic [TMR_W-1:0] TIMEOUT_LAST = TMR_W'(TIMEOUT_CYC);

    state_t           state_q, state_d;
    coin_t            sel_q, sel_d;
    logic [AMT_W-1:0] rem_q, rem_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             err_q, err_d;
    logic             jam_q, jam_d;
    logic             dec10, dec5;

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        rem_d   = rem_q;
        timer_d = timer_q;
        err_d   = err_q;
        jam_d   = jam_q;
        dec10   = 1'b0;
        dec5    = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    rem_d   = req_amt;
                    jam_d   = 1'b0;
                    err_d   = 1'b0;
                    state_d = SELECT;
                end
            end
            SELECT: begin
                timer_d = '0;
                if (rem_q == '0) begin
                    err_d   = 1'b0;
                    state_d = DONE;
                end else if ((rem_q >= AMT_W'(COIN10_UNITS)) && (stock10 != '0)) begin
                    sel_d   = COIN10;
                    state_d = EJECT;
                end else if ((rem_q >= AMT_W'(COIN5_UNITS)) && (stock5 != '0)) begin
                    sel_d   = COIN5;
                    state_d = EJECT;
                end else begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end
            end
            EJECT: begin
                if (timer_q == PULSE_LAST) begin
                    timer_d = '0;
                    state_d = WAIT_DROP;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            // A drop from the other hopper is not ours to count.
            WAIT_DROP: begin
                if ((sel_q == COIN10) && drop10) begin
                    dec10   = 1'b1;
                    rem_d   = rem_q - AMT_W'(COIN10_UNITS);
                    state_d = SELECT;
                end else if ((sel_q == COIN5) && drop5) begin
                    dec5    = 1'b1;
                    rem_d   = rem_q - AMT_W'(COIN5_UNITS);
                    state_d = SELECT;
                end else if (timer_q == TIMEOUT_LAST) begin
                    err_d   = 1'b1;
                    jam_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= COIN5;
            rem_q   <= '0;
            timer_q <= '0;
            err_q   <= 1'b0;
            jam_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            rem_q   <= rem_d;
            timer_q <= timer_d;
            err_q   <= err_d;
            jam_q   <= jam_d;
        end
    end

    coin_stock #(.CNT_W(CNT_W)) u_stock10 (
        .clk          (clk),
        .rst          (rst),
        .refill_valid (refill_valid),
        .refill_amt   (refill10),
        .dec          (dec10),
        .stock        (stock10)
    );

    coin_stock #(.CNT_W(CNT_W)) u_stock5 (
        .clk          (clk),
        .rst          (rst),
        .refill_valid (refill_valid),
        .refill_amt   (refill5),
        .dec          (dec5),
        .stock        (stock5)
    );

    // Outputs decode registered state only, so reset drops the ejects at once.
    assign req_ready = (state_q == IDLE);
    assign done      = (state_q == DONE);
    assign err       = (state_q == DONE) && err_q;
    assign remain    = rem_q;
    assign jam       = jam_q;
    assign eject10   = (state_q == EJECT) && (sel_q == COIN10);
    assign eject5    = (state_q == EJECT) && (sel_q == COIN5);

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: directed scenarios plus randomized transactions
// scored against a closed-form greedy payout model.
module tb_change_dispenser;

    localparam int AMT_W       = 5;
    localparam int CNT_W       = 8;
    localparam int PULSE_CYC   = 4;
    localparam int TIMEOUT_CYC = 1000;
    localparam int CNT_MAX     = (1 << CNT_W) - 1;
    localparam int TXN_BUDGET  = 3000;

    logic             clk = 1'b0;
    logic             rst;
    logic             req_valid;
    logic [AMT_W-1:0] req_amt;
    logic             req_ready;
    logic             done;
    logic             err;
    logic [AMT_W-1:0] remain;
    logic             jam;
    logic             eject10;
    logic             eject5;
    logic             drop10;
    logic             drop5;
    logic             refill_valid;
    logic [CNT_W-1:0] refill10;
    logic [CNT_W-1:0] refill5;
    logic [CNT_W-1:0] stock10;
    logic [CNT_W-1:0] stock5;

    change_dispenser #(
        .AMT_W       (AMT_W),
        .CNT_W       (CNT_W),
        .PULSE_CYC   (PULSE_CYC),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_amt      (req_amt),
        .req_ready    (req_ready),
        .done         (done),
        .err          (err),
        .remain       (remain),
        .jam          (jam),
        .eject10      (eject10),
        .eject5       (eject5),
        .drop10       (drop10),
        .drop5        (drop5),
        .refill_valid (refill_valid),
        .refill10     (refill10),
        .refill5      (refill5),
        .stock10      (stock10),
        .stock5       (stock5)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Model view of hopper stock.
    int m10;
    int m5;

    // Observations from the most recent transaction.
    int   obs_coins[$];
    bit   obs_done_seen;
    int   obs_done_cyc;
    int   obs_wait_entry;
    int   obs_drop_cyc;
    logic obs_err;
    logic obs_jam;
    int   obs_remain;

    // Model predictions.
    int exp_coins[$];
    int exp_remain;
    int exp_used10;
    int exp_used5;
    bit exp_err;
    bit exp_jam;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req_valid    = 1'b0;
        req_amt      = '0;
        drop10       = 1'b0;
        drop5        = 1'b0;
        refill_valid = 1'b0;
        refill10     = '0;
        refill5      = '0;
        rst          = 1'b1;
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b0;
        tick();
        m10 = 0;
        m5  = 0;
    endtask

    task automatic load_stock(input int s10, input int s5);
        do_reset();
        refill_valid = 1'b1;
        refill10     = CNT_W'(s10);
        refill5      = CNT_W'(s5);
        tick();
        refill_valid = 1'b0;
        refill10     = '0;
        refill5      = '0;
        m10 = s10;
        m5  = s5;
    endtask

    // Greedy payout in closed form: as many tens as fit, then fives.
    task automatic predict(input int amt, input int s10, input int s5, input int max_drops);
        int n10, n5, r;
        n10 = (amt / 2 < s10) ? amt / 2 : s10;
        r   = amt - 2 * n10;
        n5  = (r < s5) ? r : s5;
        exp_coins.delete();
        for (int i = 0; i < n10; i++) exp_coins.push_back(10);
        for (int i = 0; i < n5; i++) exp_coins.push_back(5);
        if (max_drops < exp_coins.size()) begin
            while (exp_coins.size() > max_drops + 1) void'(exp_coins.pop_back());
            exp_used10 = 0;
            exp_used5  = 0;
            for (int i = 0; i < max_drops; i++) begin
                if (exp_coins[i] == 10) exp_used10++;
                else exp_used5++;
            end
            exp_remain = amt - 2 * exp_used10 - exp_used5;
            exp_err    = 1'b1;
            exp_jam    = 1'b1;
        end else begin
            exp_used10 = n10;
            exp_used5  = n5;
            exp_remain = r - n5;
            exp_err    = (exp_remain != 0);
            exp_jam    = 1'b0;
        end
    endtask

    // Drives one request and acts as the hopper: answers up to max_drops
    // coins, each gap cycles after its eject pulse falls.
    task automatic run_txn(input int amt, input int max_drops, input int gap, input int refill_amt5);
        int prev, cur, plen, wait_cnt, drops_given, cyc, exp_start;
        bit pending;
        obs_coins.delete();
        obs_done_seen  = 1'b0;
        obs_done_cyc   = -1;
        obs_wait_entry = -1;
        obs_drop_cyc   = -1;
        obs_err        = 1'b0;
        obs_jam        = 1'b0;
        obs_remain     = 0;
        prev = 0; plen = 0; wait_cnt = 0; drops_given = 0; cyc = 0; pending = 1'b0;

        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ready_before_req: got %b want 1", req_ready);
        end
        req_valid = 1'b1;
        req_amt   = AMT_W'(amt);

        for (int k = 0; k < TXN_BUDGET && !obs_done_seen; k++) begin
            tick();
            cyc++;
            req_valid    = 1'b0;
            drop10       = 1'b0;
            drop5        = 1'b0;
            refill_valid = 1'b0;
            refill5      = '0;
            cur = (eject10 === 1'b1) ? 10 : ((eject5 === 1'b1) ? 5 : 0);
            if (cur != 0 && prev == 0) begin
                obs_coins.push_back(cur);
                plen = 0;
                exp_start = (obs_coins.size() == 1) ? 2 : obs_drop_cyc + 2;
                checks++;
                if (cyc != exp_start) begin
                    errors++;
                    $display("[TB] FAIL eject_start: coin %0d at cycle %0d want %0d", obs_coins.size(), cyc, exp_start);
                end
            end
            if (cur != 0) plen++;
            if (cur == 0 && prev != 0) begin
                checks++;
                if (plen != PULSE_CYC) begin
                    errors++;
                    $display("[TB] FAIL pulse_len: got %0d want %0d", plen, PULSE_CYC);
                end
                obs_wait_entry = cyc;
                if (drops_given < max_drops) begin
                    pending  = 1'b1;
                    wait_cnt = 0;
                end
            end
            if (pending) begin
                if (wait_cnt == gap) begin
                    if (obs_coins[$] == 10) drop10 = 1'b1;
                    else drop5 = 1'b1;
                    if (refill_amt5 > 0) begin
                        refill_valid = 1'b1;
                        refill5      = CNT_W'(refill_amt5);
                    end
                    pending      = 1'b0;
                    drops_given++;
                    obs_drop_cyc = cyc;
                end else begin
                    wait_cnt++;
                end
            end
            if (done === 1'b1) begin
                obs_done_seen = 1'b1;
                obs_done_cyc  = cyc;
                obs_err       = err;
                obs_jam       = jam;
                obs_remain    = int'(remain);
            end
            prev = cur;
        end

        checks++;
        if (!obs_done_seen) begin
            errors++;
            $display("[TB] FAIL txn_timeout: no done within %0d cycles want done", TXN_BUDGET);
        end else begin
            tick();
            checks++;
            if (done !== 1'b0 || req_ready !== 1'b1) begin
                errors++;
                $display("[TB] FAIL done_pulse: done=%b ready=%b want done=0 ready=1", done, req_ready);
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({req_ready, done, err, jam, eject10, eject5} !== 6'b100000) begin
            errors++;
            $display("[TB] FAIL reset_flags: got %b want 100000", {req_ready, done, err, jam, eject10, eject5});
        end
        checks++;
        if (remain !== '0 || stock10 !== '0 || stock5 !== '0) begin
            errors++;
            $display("[TB] FAIL reset_values: remain=%0d s10=%0d s5=%0d want 0 0 0", remain, stock10, stock5);
        end
    endtask

    task automatic test_mixed_coins();
        load_stock(2, 2);
        run_txn(3, 99, 2, 0);
        checks++;
        if (!(obs_coins.size() == 2 && obs_coins[0] == 10 && obs_coins[1] == 5)) begin
            errors++;
            $display("[TB] FAIL mixed_seq: got %0d coins want 2 coins (10 then 5)", obs_coins.size());
        end
        checks++;
        if (obs_err !== 1'b0 || obs_remain != 0) begin
            errors++;
            $display("[TB] FAIL mixed_result: err=%b remain=%0d want err=0 remain=0", obs_err, obs_remain);
        end
        checks++;
        if (stock10 !== 8'd1 || stock5 !== 8'd1) begin
            errors++;
            $display("[TB] FAIL mixed_stock: s10=%0d s5=%0d want 1 1", stock10, stock5);
        end
    endtask

    task automatic test_fives_only();
        load_stock(0, 5);
        run_txn(4, 99, 1, 0);
        checks++;
        if (!(obs_coins.size() == 4 && obs_coins[0] == 5 && obs_coins[3] == 5)) begin
            errors++;
            $display("[TB] FAIL fives_seq: got %0d coins want 4 fives", obs_coins.size());
        end
        checks++;
        if (obs_err !== 1'b0 || stock5 !== 8'd1) begin
            errors++;
            $display("[TB] FAIL fives_result: err=%b s5=%0d want err=0 s5=1", obs_err, stock5);
        end
    endtask

    task automatic test_shortfall();
        load_stock(1, 0);
        run_txn(3, 99, 2, 0);
        checks++;
        if (!(obs_coins.size() == 1 && obs_coins[0] == 10)) begin
            errors++;
            $display("[TB] FAIL short_seq: got %0d coins want one ten", obs_coins.size());
        end
        checks++;
        if (obs_err !== 1'b1 || obs_remain != 1 || obs_jam !== 1'b0 || stock10 !== 8'd0) begin
            errors++;
            $display("[TB] FAIL short_result: err=%b remain=%0d jam=%b s10=%0d want 1 1 0 0",
                     obs_err, obs_remain, obs_jam, stock10);
        end
        checks++;
        if (obs_done_cyc - obs_drop_cyc != 2) begin
            errors++;
            $display("[TB] FAIL short_latency: done %0d cycles after drop want 2", obs_done_cyc - obs_drop_cyc);
        end
    endtask

    task automatic test_timeout();
        load_stock(1, 0);
        run_txn(2, 0, 0, 0);
        checks++;
        if (obs_done_cyc - obs_wait_entry != TIMEOUT_CYC + 1) begin
            errors++;
            $display("[TB] FAIL timeout_latency: got %0d want %0d", obs_done_cyc - obs_wait_entry, TIMEOUT_CYC + 1);
        end
        checks++;
        if (obs_err !== 1'b1 || obs_jam !== 1'b1 || obs_remain != 2 || stock10 !== 8'd1) begin
            errors++;
            $display("[TB] FAIL timeout_result: err=%b jam=%b remain=%0d s10=%0d want 1 1 2 1",
                     obs_err, obs_jam, obs_remain, stock10);
        end
        tick();
        checks++;
        if (jam !== 1'b1) begin
            errors++;
            $display("[TB] FAIL jam_sticky: got %b want 1", jam);
        end
        run_txn(0, 99, 0, 0);
        checks++;
        if (obs_jam !== 1'b0 || obs_err !== 1'b0 || obs_done_cyc != 2) begin
            errors++;
            $display("[TB] FAIL jam_clear_zero: jam=%b err=%b done_cyc=%0d want 0 0 2", obs_jam, obs_err, obs_done_cyc);
        end
    endtask

    task automatic test_refill_with_drop();
        load_stock(0, 250);
        run_txn(1, 99, 1, 10);
        checks++;
        if (stock5 !== 8'd255) begin
            errors++;
            $display("[TB] FAIL refill_saturate: got %0d want 255", stock5);
        end
        load_stock(0, 3);
        run_txn(1, 99, 1, 2);
        checks++;
        if (stock5 !== 8'd4) begin
            errors++;
            $display("[TB] FAIL refill_net: got %0d want 4", stock5);
        end
    endtask

    task automatic test_stray_drops();
        load_stock(2, 2);
        drop10 = 1'b1;
        drop5  = 1'b1;
        tick();
        drop10 = 1'b0;
        drop5  = 1'b0;
        tick();
        checks++;
        if (stock10 !== 8'd2 || stock5 !== 8'd2 || req_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL stray_drop: s10=%0d s5=%0d ready=%b want 2 2 1", stock10, stock5, req_ready);
        end
    endtask

    task automatic test_reset_mid_eject();
        bit seen;
        int done_cnt;
        seen = 1'b0;
        done_cnt = 0;
        load_stock(2, 2);
        req_valid = 1'b1;
        req_amt   = AMT_W'(3);
        tick();
        req_valid = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            tick();
            if (eject10 === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("[TB] FAIL midreset_eject_seen: got no eject10 want eject10");
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (eject10 !== 1'b0 || eject5 !== 1'b0 || req_ready !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midreset_outputs: e10=%b e5=%b ready=%b done=%b want 0 0 1 0",
                     eject10, eject5, req_ready, done);
        end
        checks++;
        if (stock10 !== '0 || stock5 !== '0 || remain !== '0) begin
            errors++;
            $display("[TB] FAIL midreset_values: s10=%0d s5=%0d remain=%0d want 0 0 0", stock10, stock5, remain);
        end
        @(posedge clk);
        #3;
        rst = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (done === 1'b1) done_cnt++;
        end
        checks++;
        if (done_cnt != 0) begin
            errors++;
            $display("[TB] FAIL midreset_no_done: got %0d done pulses want 0", done_cnt);
        end
    endtask

    task automatic test_random();
        int r10, r5, amt, gap, max_drops;
        bit seq_ok;
        do_reset();
        for (int it = 0; it < 25; it++) begin
            r10 = $urandom_range(0, 5);
            r5  = $urandom_range(0, 8);
            refill_valid = 1'b1;
            refill10     = CNT_W'(r10);
            refill5      = CNT_W'(r5);
            tick();
            refill_valid = 1'b0;
            refill10     = '0;
            refill5      = '0;
            m10 = (m10 + r10 > CNT_MAX) ? CNT_MAX : m10 + r10;
            m5  = (m5 + r5 > CNT_MAX) ? CNT_MAX : m5 + r5;

            amt       = $urandom_range(0, (1 << AMT_W) - 1);
            gap       = $urandom_range(0, 3);
            max_drops = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 2) : 99;
            predict(amt, m10, m5, max_drops);
            run_txn(amt, max_drops, gap, 0);

            seq_ok = (obs_coins.size() == exp_coins.size());
            if (seq_ok) begin
                for (int i = 0; i < exp_coins.size(); i++) begin
                    if (obs_coins[i] != exp_coins[i]) seq_ok = 1'b0;
                end
            end
            checks++;
            if (!seq_ok) begin
                errors++;
                $display("[TB] FAIL rand_seq it=%0d amt=%0d: got %0d coins want %0d", it, amt, obs_coins.size(), exp_coins.size());
            end
            checks++;
            if (obs_err !== exp_err || obs_jam !== exp_jam || obs_remain != exp_remain) begin
                errors++;
                $display("[TB] FAIL rand_result it=%0d: err=%b jam=%b remain=%0d want %b %b %0d",
                         it, obs_err, obs_jam, obs_remain, exp_err, exp_jam, exp_remain);
            end
            m10 = m10 - exp_used10;
            m5  = m5 - exp_used5;
            checks++;
            if (int'(stock10) != m10 || int'(stock5) != m5) begin
                errors++;
                $display("[TB] FAIL rand_stock it=%0d: s10=%0d s5=%0d want %0d %0d", it, stock10, stock5, m10, m5);
            end
        end
    endtask

    initial begin
        test_reset();
        test_mixed_coins();
        test_fives_only();
        test_shortfall();
        test_timeout();
        test_refill_with_drop();
        test_stray_drops();
        test_reset_mid_eject();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
